// File: rtl/flood_board_gen_if.sv
// Setup/board-store bus for flood_board_gen.
// The game-setup FSM drives START and the board configuration (master side).
// The generator (slave side) returns the registered cell write port and the
// BUSY/DONE/ERR status flags.
//   START      level request, sampled only while the generator is idle
//   seed       16-bit LFSR seed, 0 selects the generator's default seed
//   SIZE       board edge, legal 2..MAX_SIZE
//   COLOR_NUM  number of colours, legal 2..2^COLOR_W (3.. with NO_ADJ)
//   NO_ADJ     forbid a cell matching its left or upper neighbour
//   WR_EN      one-cycle write strobe for WR_ROW/WR_COL/WR_COLOR
//   BUSY       generation in progress
//   DONE       board complete, held until START drops
//   ERR        configuration rejected, held until START drops
interface flood_board_gen_if #(
   parameter int unsigned MAX_SIZE = 26,
   parameter int unsigned COLOR_W  = 3
);
   localparam int unsigned RW = $clog2(MAX_SIZE);
   localparam int unsigned SW = $clog2(MAX_SIZE + 1);

   logic               START;
   logic [15:0]        seed;
   logic [SW-1:0]      SIZE;
   logic [COLOR_W:0]   COLOR_NUM;
   logic               NO_ADJ;

   logic               WR_EN;
   logic [RW-1:0]      WR_ROW;
   logic [RW-1:0]      WR_COL;
   logic [COLOR_W-1:0] WR_COLOR;
   logic               BUSY;
   logic               DONE;
   logic               ERR;

   modport master (
      output START, seed, SIZE, COLOR_NUM, NO_ADJ,
      input  WR_EN, WR_ROW, WR_COL, WR_COLOR, BUSY, DONE, ERR
   );

   modport slave (
      input  START, seed, SIZE, COLOR_NUM, NO_ADJ,
      output WR_EN, WR_ROW, WR_COL, WR_COLOR, BUSY, DONE, ERR
   );
endinterface

// File: rtl/flood_board_gen.sv
// Flood-It board generator.
// On START it validates and latches the configuration, seeds a 16-bit LFSR and
// walks the board in row-major order, emitting one registered write per cell.
// Each GEN cycle steps the LFSR and tries the low COLOR_W bits as a colour;
// out-of-range or (with NO_ADJ) neighbour-matching candidates are rejected.
// After 16 failed tries the smallest legal colour is used, so every cell
// finishes within 16 cycles.
// Ports:
//   CLOCK  rising-edge clock
//   RESET  asynchronous active-high reset
//   bus    flood_board_gen_if slave side (config in, write port and status out)
module flood_board_gen #(
   parameter int unsigned MAX_SIZE     = 26,
   parameter int unsigned COLOR_W      = 3,
   parameter logic [15:0] DEFAULT_SEED = 16'hDAD7
) (
   input  logic             CLOCK,
   input  logic             RESET,
   flood_board_gen_if.slave bus
);
   localparam int unsigned RW      = $clog2(MAX_SIZE);
   localparam int unsigned SW      = $clog2(MAX_SIZE + 1);
   localparam int unsigned CW      = COLOR_W + 1;
   localparam int unsigned NCOLORS = 1 << COLOR_W;
   localparam int unsigned AW      = 4;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_GEN    = 2'd1;
   localparam logic [1:0] S_FINISH = 2'd2;
   localparam logic [1:0] S_HOLD   = 2'd3;

   // Control and datapath state
   logic [1:0]         state_q,    state_d;
   logic [15:0]        lfsr_q,     lfsr_d;
   logic [SW-1:0]      size_q,     size_d;
   logic [CW-1:0]      ncol_q,     ncol_d;
   logic               noadj_q,    noadj_d;
   logic [RW-1:0]      row_q,      row_d;
   logic [RW-1:0]      col_q,      col_d;
   logic [AW-1:0]      attempt_q,  attempt_d;
   logic [COLOR_W-1:0] left_q,     left_d;

   // Registered outputs
   logic               wr_en_q,    wr_en_d;
   logic [RW-1:0]      wr_row_q,   wr_row_d;
   logic [RW-1:0]      wr_col_q,   wr_col_d;
   logic [COLOR_W-1:0] wr_color_q, wr_color_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;
   logic               err_q,      err_d;

   // Row buffer: colour of the cell above each column
   logic [COLOR_W-1:0] above_q [MAX_SIZE];

   // Combinational helpers
   logic               cfg_ok_c;
   logic [COLOR_W-1:0] cand_c;
   logic [COLOR_W-1:0] above_c;
   logic               chk_left_c;
   logic               chk_up_c;
   logic               accept_c;
   logic [COLOR_W-1:0] fb_color_c;
   logic [COLOR_W-1:0] pick_c;
   logic               last_col_c;
   logic               last_row_c;
   logic               above_we_c;
   logic [15:0]        lfsr_step_c;

   // True when colour c is in range and differs from the enabled neighbours
   function automatic logic fits(
      input logic [COLOR_W-1:0] c,
      input logic [CW-1:0]      n,
      input logic               chk_l,
      input logic [COLOR_W-1:0] l,
      input logic               chk_u,
      input logic [COLOR_W-1:0] u
   );
      return ({1'b0, c} < n) && !(chk_l && (c == l)) && !(chk_u && (c == u));
   endfunction

   // Configuration legality, evaluated on the live inputs at the START edge
   always_comb begin
      cfg_ok_c = (bus.SIZE >= SW'(2)) && (bus.SIZE <= SW'(MAX_SIZE)) &&
                 (bus.COLOR_NUM >= CW'(2)) && (bus.COLOR_NUM <= CW'(NCOLORS)) &&
                 !(bus.NO_ADJ && (bus.COLOR_NUM < CW'(3)));
   end

   // Candidate evaluation and smallest-legal-colour fallback
   always_comb begin
      lfsr_step_c = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      cand_c      = lfsr_q[COLOR_W-1:0];
      above_c     = above_q[col_q];
      chk_left_c  = noadj_q && (col_q != '0);
      chk_up_c    = noadj_q && (row_q != '0);
      accept_c    = fits(cand_c, ncol_q, chk_left_c, left_q, chk_up_c, above_c);
      // Descending scan so the last hit is the smallest legal colour
      fb_color_c  = '0;
      for (int i = int'(NCOLORS) - 1; i >= 0; i--) begin
         if (fits(COLOR_W'(i), ncol_q, chk_left_c, left_q, chk_up_c, above_c)) begin
            fb_color_c = COLOR_W'(i);
         end
      end
      pick_c      = accept_c ? cand_c : fb_color_c;
      last_col_c  = (SW'(col_q) == (size_q - SW'(1)));
      last_row_c  = (SW'(row_q) == (size_q - SW'(1)));
   end

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      lfsr_d     = lfsr_q;
      size_d     = size_q;
      ncol_d     = ncol_q;
      noadj_d    = noadj_q;
      row_d      = row_q;
      col_d      = col_q;
      attempt_d  = attempt_q;
      left_d     = left_q;
      wr_en_d    = 1'b0;
      wr_row_d   = wr_row_q;
      wr_col_d   = wr_col_q;
      wr_color_d = wr_color_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      above_we_c = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               size_d  = bus.SIZE;
               ncol_d  = bus.COLOR_NUM;
               noadj_d = bus.NO_ADJ;
               if (!cfg_ok_c) begin
                  err_d   = 1'b1;
                  state_d = S_HOLD;
               end else begin
                  lfsr_d    = (bus.seed != 16'h0) ? bus.seed : DEFAULT_SEED;
                  row_d     = '0;
                  col_d     = '0;
                  attempt_d = '0;
                  busy_d    = 1'b1;
                  state_d   = S_GEN;
               end
            end
         end

         S_GEN: begin
            // The LFSR advances every GEN cycle, accepted or not
            lfsr_d = lfsr_step_c;
            if (accept_c || (attempt_q == AW'(15))) begin
               wr_en_d    = 1'b1;
               wr_row_d   = row_q;
               wr_col_d   = col_q;
               wr_color_d = pick_c;
               left_d     = pick_c;
               above_we_c = 1'b1;
               attempt_d  = '0;
               if (last_col_c) begin
                  col_d = '0;
                  if (last_row_c) begin
                     state_d = S_FINISH;
                  end else begin
                     row_d = row_q + RW'(1);
                  end
               end else begin
                  col_d = col_q + RW'(1);
               end
            end else begin
               attempt_d = attempt_q + AW'(1);
            end
         end

         S_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_HOLD;
         end

         S_HOLD: begin
            // Holding START keeps the result visible and blocks a restart
            if (!bus.START) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         lfsr_q     <= DEFAULT_SEED;
         size_q     <= '0;
         ncol_q     <= '0;
         noadj_q    <= 1'b0;
         row_q      <= '0;
         col_q      <= '0;
         attempt_q  <= '0;
         left_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_row_q   <= '0;
         wr_col_q   <= '0;
         wr_color_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         lfsr_q     <= lfsr_d;
         size_q     <= size_d;
         ncol_q     <= ncol_d;
         noadj_q    <= noadj_d;
         row_q      <= row_d;
         col_q      <= col_d;
         attempt_q  <= attempt_d;
         left_q     <= left_d;
         wr_en_q    <= wr_en_d;
         wr_row_q   <= wr_row_d;
         wr_col_q   <= wr_col_d;
         wr_color_q <= wr_color_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   // Row buffer is only read for row>0, after it has been written, so no reset
   always_ff @(posedge CLOCK) begin
      if (above_we_c) begin
         above_q[col_q] <= pick_c;
      end
   end

   assign bus.WR_EN    = wr_en_q;
   assign bus.WR_ROW   = wr_row_q;
   assign bus.WR_COL   = wr_col_q;
   assign bus.WR_COLOR = wr_color_q;
   assign bus.BUSY     = busy_q;
   assign bus.DONE     = done_q;
   assign bus.ERR      = err_q;
endmodule
